// File: rtl/mdu_issue_ctrl_if.sv
// ----------------------------------------------------------------------------
// mdu_issue_ctrl_if
// Bundles the E-stage instruction/operand inputs, the MDU busy flag and the
// command/status outputs of the multiply/divide issue controller.
//   master : pipeline/MDU side, drives e_valid, e_md_op, e_rs, e_rt, mdu_busy
//            and observes every controller output.
//   slave  : the issue controller itself.
// ----------------------------------------------------------------------------
interface mdu_issue_ctrl_if;
    logic        e_valid;
    logic [3:0]  e_md_op;
    logic [31:0] e_rs;
    logic [31:0] e_rt;
    logic        mdu_busy;

    logic        start;
    logic [2:0]  MDUOp;
    logic        HIWE;
    logic        LOWE;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        stall;
    logic        proto_err;
    logic [15:0] issue_cnt;
    logic [15:0] stall_cnt;

    modport master (
        output e_valid, e_md_op, e_rs, e_rt, mdu_busy,
        input  start, MDUOp, HIWE, LOWE, in1, in2, stall, proto_err,
               issue_cnt, stall_cnt
    );

    modport slave (
        input  e_valid, e_md_op, e_rs, e_rt, mdu_busy,
        output start, MDUOp, HIWE, LOWE, in1, in2, stall, proto_err,
               issue_cnt, stall_cnt
    );
endinterface

// File: rtl/mdu_issue_ctrl.sv
// ----------------------------------------------------------------------------
// mdu_issue_ctrl
// Issues multiply/divide/HI-LO-move commands from the E stage to the MDU and
// stalls the pipeline while a multiply (5 cycles) or divide (10 cycles) is in
// flight. A shadow counter tracks the expected MDU latency independently of
// the MDU busy flag; disagreement between the two raises a sticky proto_err.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : slave modport of mdu_issue_ctrl_if (E-stage op/operands, mdu_busy
//           in; start/MDUOp/HIWE/LOWE/in1/in2, stall, proto_err and saturating
//           issue/stall statistics out)
// ----------------------------------------------------------------------------
module mdu_issue_ctrl (
    input  logic           clk,
    input  logic           reset,
    mdu_issue_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_WAIT = 2'd1,
        DIV_WAIT = 2'd2
    } state_e;

    state_e      state_q;
    logic [3:0]  shadow_cnt_q;
    logic        start_q;
    logic        proto_err_q;
    logic [15:0] issue_cnt_q;
    logic [15:0] stall_cnt_q;

    logic [3:0]  op;
    logic        is_mul, is_div, md_start, md_write, md_read, md_class;
    logic        stall_c, start_c, hiwe_c, lowe_c, mismatch;

    assign op       = bus.e_md_op;
    assign is_mul   = (op == 4'd1) || (op == 4'd2);
    assign is_div   = (op == 4'd3) || (op == 4'd4);
    assign md_start = is_mul || is_div;
    assign md_write = (op == 4'd5) || (op == 4'd6);
    assign md_read  = (op == 4'd7) || (op == 4'd8);
    assign md_class = md_start || md_write || md_read;

    assign stall_c = !reset && bus.e_valid && md_class &&
                     (bus.mdu_busy || (shadow_cnt_q != 4'd0));
    assign start_c = !reset && bus.e_valid && md_start && !stall_c;
    assign hiwe_c  = !reset && bus.e_valid && (op == 4'd5) && !stall_c;
    assign lowe_c  = !reset && bus.e_valid && (op == 4'd6) && !stall_c;

    always_comb begin
        bus.MDUOp = 3'b000;
        case (op)
            4'd2:    bus.MDUOp = 3'b001;
            4'd3:    bus.MDUOp = 3'b010;
            4'd4:    bus.MDUOp = 3'b011;
            default: bus.MDUOp = 3'b000;
        endcase
    end

    // The MDU must report busy right after a start, and must be idle whenever
    // the shadow FSM is idle, except in the cycle just after a start.
    assign mismatch = (start_q && !bus.mdu_busy) ||
                      ((state_q == IDLE) && !start_q && bus.mdu_busy);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            shadow_cnt_q <= '0;
            start_q      <= 1'b0;
            proto_err_q  <= 1'b0;
            issue_cnt_q  <= '0;
            stall_cnt_q  <= '0;
        end else begin
            start_q <= start_c;
            if (mismatch)
                proto_err_q <= 1'b1;
            if ((start_c || hiwe_c || lowe_c) && (issue_cnt_q != 16'hFFFF))
                issue_cnt_q <= issue_cnt_q + 16'd1;
            if (stall_c && (stall_cnt_q != 16'hFFFF))
                stall_cnt_q <= stall_cnt_q + 16'd1;

            case (state_q)
                IDLE: begin
                    if (start_c) begin
                        if (is_mul) begin
                            state_q      <= MUL_WAIT;
                            shadow_cnt_q <= 4'd5;
                        end else begin
                            state_q      <= DIV_WAIT;
                            shadow_cnt_q <= 4'd10;
                        end
                    end
                end
                MUL_WAIT, DIV_WAIT: begin
                    shadow_cnt_q <= shadow_cnt_q - 4'd1;
                    if (shadow_cnt_q == 4'd1)
                        state_q <= IDLE;
                end
                default: begin
                    state_q      <= IDLE;
                    shadow_cnt_q <= '0;
                end
            endcase
        end
    end

    assign bus.start     = start_c;
    assign bus.HIWE      = hiwe_c;
    assign bus.LOWE      = lowe_c;
    assign bus.stall     = stall_c;
    assign bus.in1       = bus.e_rs;
    assign bus.in2       = bus.e_rt;
    assign bus.proto_err = proto_err_q;
    assign bus.issue_cnt = issue_cnt_q;
    assign bus.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mdu_issue_ctrl
// Drives the issue controller with directed scenarios and a random phase.
// Expectations come from a cycle-indexed reference model: an issued op makes
// the MDU "free" again at a known future cycle, MD ops before that cycle (or
// while the MDU says busy) stall, and the busy protocol is judged against the
// cycle of the last start. A small MDU model drives mdu_busy.
// ----------------------------------------------------------------------------
module tb_mdu_issue_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mdu_issue_ctrl_if bus();

    mdu_issue_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int ntests = 0;
    int nfail  = 0;

    // reference model state
    int cyc        = 0;
    int free_at    = 0;
    int last_start = -100;
    int mdu_cnt    = 0;
    int extra      = 0;
    int icnt       = 0;
    int scnt       = 0;
    bit perr       = 1'b0;

    // last observed outputs
    logic        obs_stall, obs_start, obs_hiwe;
    logic [2:0]  obs_op;
    logic [31:0] obs_in1, obs_in2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic iv, input logic [3:0] iop,
                        input logic [31:0] irs, input logic [31:0] irt,
                        input logic irst);
        bit busy, mdc, mds, e_stall, e_start, e_hi, e_lo, mism;
        int lat, e_sh;
        logic [2:0] e_op;
        busy = (mdu_cnt > 0);
        reset        = irst;
        bus.e_valid  = iv;
        bus.e_md_op  = iop;
        bus.e_rs     = irs;
        bus.e_rt     = irt;
        bus.mdu_busy = busy;
        #1;
        mdc     = (iop >= 4'd1) && (iop <= 4'd8);
        mds     = (iop >= 4'd1) && (iop <= 4'd4);
        e_stall = !irst && iv && mdc && (busy || (cyc < free_at));
        e_start = !irst && iv && mds && !e_stall;
        e_hi    = !irst && iv && (iop == 4'd5) && !e_stall;
        e_lo    = !irst && iv && (iop == 4'd6) && !e_stall;
        e_op    = (iop == 4'd2) ? 3'd1 : (iop == 4'd3) ? 3'd2 : (iop == 4'd4) ? 3'd3 : 3'd0;
        e_sh    = (cyc < free_at) ? (free_at - cyc) : 0;

        chk("stall",      {31'd0, bus.stall},     {31'd0, e_stall});
        chk("start",      {31'd0, bus.start},     {31'd0, e_start});
        chk("HIWE",       {31'd0, bus.HIWE},      {31'd0, e_hi});
        chk("LOWE",       {31'd0, bus.LOWE},      {31'd0, e_lo});
        chk("MDUOp",      {29'd0, bus.MDUOp},     {29'd0, e_op});
        chk("in1",        bus.in1,                irs);
        chk("in2",        bus.in2,                irt);
        chk("proto_err",  {31'd0, bus.proto_err}, {31'd0, perr});
        chk("issue_cnt",  {16'd0, bus.issue_cnt}, icnt);
        chk("stall_cnt",  {16'd0, bus.stall_cnt}, scnt);
        chk("shadow_cnt", {28'd0, dut.shadow_cnt_q}, e_sh);

        obs_stall = bus.stall;
        obs_start = bus.start;
        obs_hiwe  = bus.HIWE;
        obs_op    = bus.MDUOp;
        obs_in1   = bus.in1;
        obs_in2   = bus.in2;

        @(posedge clk);
        if (irst) begin
            free_at    = 0;
            last_start = -100;
            perr       = 1'b0;
            icnt       = 0;
            scnt       = 0;
            mdu_cnt    = 0;
        end else begin
            if (cyc == last_start + 1) mism = !busy;
            else                       mism = (cyc >= free_at) && busy;
            if (mism) perr = 1'b1;
            if ((e_start || e_hi || e_lo) && icnt < 65535) icnt++;
            if (e_stall && scnt < 65535) scnt++;
            if (mdu_cnt > 0) mdu_cnt--;
            if (e_start) begin
                lat        = (iop <= 4'd2) ? 5 : 10;
                free_at    = cyc + lat + 1;
                last_start = cyc;
                mdu_cnt    = lat + extra;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    // Repeats one MD instruction in E until it is no longer stalled.
    task automatic issue(input logic [3:0] iop, input logic [31:0] irs,
                         input logic [31:0] irt, input int maxc, output int stalls);
        bit done = 1'b0;
        int n = 0;
        stalls = 0;
        while (!done && n < maxc) begin
            step(1'b1, iop, irs, irt, 1'b0);
            if (obs_stall) stalls++;
            else           done = 1'b1;
            n++;
        end
        chk("issue_timeout", {31'd0, done}, 32'd1);
    endtask

    task automatic do_reset();
        step(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        int nst;
        logic [31:0] ra, rb;

        reset        = 1'b1;
        bus.e_valid  = 1'b0;
        bus.e_md_op  = 4'd0;
        bus.e_rs     = '0;
        bus.e_rt     = '0;
        bus.mdu_busy = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // reset state
        do_reset();

        // mult -3 * 7 then mflo
        step(1'b1, 4'd2, 32'hFFFF_FFFD, 32'd7, 1'b0);
        chk("mult_start", {31'd0, obs_start}, 32'd1);
        chk("mult_mduop", {29'd0, obs_op}, 32'd1);
        issue(4'd8, 32'd0, 32'd0, 20, st);
        chk("mflo_stalls", st, 32'd5);
        chk("mult_stall_cnt", {16'd0, bus.stall_cnt}, 32'd5);
        chk("mult_issue_cnt", {16'd0, bus.issue_cnt}, 32'd1);
        chk("mult_proto_err", {31'd0, bus.proto_err}, 32'd0);

        // divu then back-to-back divu with new operands
        do_reset();
        step(1'b1, 4'd3, 32'd100, 32'd7, 1'b0);
        issue(4'd3, 32'hDEAD_BEEF, 32'h0000_1234, 20, st);
        chk("divu2_stalls", st, 32'd10);
        chk("divu2_start", {31'd0, obs_start}, 32'd1);
        chk("divu2_in1", obs_in1, 32'hDEAD_BEEF);
        chk("divu2_in2", obs_in2, 32'h0000_1234);
        chk("divu2_issue_cnt", {16'd0, bus.issue_cnt}, 32'd2);

        // mthi during MUL_WAIT
        do_reset();
        step(1'b1, 4'd1, 32'd3, 32'd4, 1'b0);
        issue(4'd5, 32'hCAFE_F00D, 32'd0, 20, st);
        chk("mthi_stalls", st, 32'd5);
        chk("mthi_hiwe", {31'd0, obs_hiwe}, 32'd1);
        chk("mthi_in1", obs_in1, 32'hCAFE_F00D);

        // non-MD stream during DIV_WAIT
        do_reset();
        step(1'b1, 4'd4, 32'd50, 32'd5, 1'b0);
        nst = 0;
        for (int i = 0; i < 11; i++) begin
            step(1'b1, 4'd0, $urandom, $urandom, 1'b0);
            if (obs_stall) nst++;
        end
        chk("addu_nostall", nst, 32'd0);
        chk("addu_shadow_end", {28'd0, dut.shadow_cnt_q}, 32'd0);

        // MDU holds busy one extra cycle after a mult
        do_reset();
        extra = 1;
        step(1'b1, 4'd2, 32'd9, 32'd9, 1'b0);
        issue(4'd8, 32'd0, 32'd0, 20, st);
        extra = 0;
        chk("extra_stalls", st, 32'd6);
        chk("extra_proto_err", {31'd0, bus.proto_err}, 32'd1);
        repeat (3) step(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        chk("proto_err_sticky", {31'd0, bus.proto_err}, 32'd1);

        // reset in the middle of DIV_WAIT
        do_reset();
        step(1'b1, 4'd3, 32'd1, 32'd1, 1'b0);
        repeat (3) step(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        chk("div_shadow_7", {28'd0, dut.shadow_cnt_q}, 32'd7);
        do_reset();
        chk("rst_issue_cnt", {16'd0, bus.issue_cnt}, 32'd0);
        chk("rst_stall_cnt", {16'd0, bus.stall_cnt}, 32'd0);
        step(1'b1, 4'd7, 32'd0, 32'd0, 1'b0);
        chk("mfhi_after_rst", {31'd0, obs_stall}, 32'd0);

        // randomized phase
        do_reset();
        for (int i = 0; i < 400; i++) begin
            ra = $urandom;
            rb = $urandom;
            step(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), ra, rb,
                 ($urandom_range(0, 59) == 0));
        end

        // issue_cnt saturation via a stream of mtlo
        do_reset();
        for (int i = 0; i < 65540; i++)
            step(1'b1, 4'd6, 32'(i), 32'd0, 1'b0);
        chk("issue_cnt_sat", {16'd0, bus.issue_cnt}, 32'h0000_FFFF);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule

// File: doc/mdu_issue_ctrl.md
MDU_ISSUE_CTRL -- requirements
Module: mdu_issue_ctrl

Interface
REQ-001 SHALL use one clock and a synchronous active-high reset: clk input 1 rising-edge clock; reset input 1 synchronous active-high reset.
REQ-002 SHALL have e_valid input 1: E-stage instruction valid.
REQ-003 SHALL have e_md_op input 4: 0 none, 1 multu, 2 mult, 3 divu, 4 div, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo; 9-15 treated as none.
REQ-004 SHALL have e_rs input 32 and e_rt input 32: forwarded E-stage operands.
REQ-005 SHALL have mdu_busy input 1: busy flag from the multiply/divide unit.
REQ-006 SHALL have start output 1, MDUOp output 3, HIWE output 1, LOWE output 1, in1 output 32 and in2 output 32: command to the multiply/divide unit.
REQ-007 SHALL have stall output 1: freeze F/D/E and bubble M.
REQ-008 SHALL have proto_err output 1: sticky busy-mismatch flag.
REQ-009 SHALL have issue_cnt output 16 and stall_cnt output 16: saturating statistics.

Function
REQ-010 SHALL class ops 1-4 as MD-start, 5-6 as MD-write and 7-8 as MD-read; any of 1-8 is MD-class.
REQ-011 SHALL drive stall combinationally = e_valid & MD-class & (mdu_busy | shadow_cnt != 0).
REQ-012 SHALL drive start combinationally = e_valid & MD-start & !stall.
REQ-013 SHALL map MDUOp as multu 000, mult 001, divu 010, div 011, else 000.
REQ-014 SHALL drive HIWE = e_valid & op 5 & !stall, and LOWE = e_valid & op 6 & !stall; they are never both 1 and never 1 with start.
REQ-015 SHALL drive in1 = e_rs and in2 = e_rt combinationally in every cycle.
REQ-016 SHALL implement an FSM with states IDLE, MUL_WAIT and DIV_WAIT, plus a 4-bit shadow_cnt.
REQ-017 On start with op 1/2, SHALL go IDLE->MUL_WAIT and set shadow_cnt=5; with op 3/4, IDLE->DIV_WAIT and set shadow_cnt=10.
REQ-018 In MUL_WAIT/DIV_WAIT, SHALL decrement shadow_cnt each cycle and return to IDLE on the edge where shadow_cnt goes 1->0.
REQ-019 SHALL make start impossible outside IDLE, because stall holds while shadow_cnt != 0.
REQ-020 SHALL keep the start-to-next-MD-instruction latency at exactly 5 stall cycles for multiplies and 10 for divides, with the MD-class instruction in E proceeding in the cycle after shadow_cnt reaches 0.
REQ-021 SHALL not stall non-MD instructions regardless of MDU state.
REQ-022 SHALL compare each cycle: in the cycle after a start, mdu_busy SHALL be 1; whenever the FSM is IDLE and no start occurred in the previous cycle, mdu_busy SHALL be 0.
REQ-023 SHALL set proto_err on either mismatch in REQ-022 and hold it until reset.
REQ-024 SHALL raise stall if mdu_busy=1 while shadow_cnt=0, which is the mismatch case, but SHALL not alter the FSM.
REQ-025 SHALL increment issue_cnt on each start and each HIWE/LOWE pulse, and SHALL hold it at 16'hFFFF once it saturates.
REQ-026 SHALL increment stall_cnt on each cycle where stall=1, saturating at 16'hFFFF.
REQ-027 SHALL treat a back-to-back MD-start in E immediately after an issue as stalled for the full latency, then issue with fresh operands.
REQ-028 SHALL make e_valid=0 suppress start, HIWE, LOWE and stall in that cycle; the FSM keeps counting.

Reset
REQ-029 On reset, SHALL set FSM=IDLE, shadow_cnt=0, proto_err=0, issue_cnt=0 and stall_cnt=0.
REQ-030 SHALL give reset priority over every event, including reset during MUL_WAIT/DIV_WAIT: the next cycle is IDLE and any MD op proceeds if mdu_busy=0.
REQ-031 SHALL force combinational outputs to 0 while reset=1 (stall, start, HIWE, LOWE).

Verification
REQ-032 Bench SHALL cover: mult rs=-3, rt=7, MDU model busy 5 cycles, then mflo -> start 1 cycle with MDUOp=001, mflo stalled 5 cycles, stall_cnt=5, issue_cnt=1, proto_err=0.
REQ-033 Bench SHALL cover: divu then divu back-to-back -> second stalled 10 cycles, second start carries the new e_rs/e_rt, issue_cnt=2.
REQ-034 Bench SHALL cover: mthi during MUL_WAIT -> stalled, HIWE=0 until shadow_cnt=0, then HIWE=1 for one cycle with in1=e_rs.
REQ-035 Bench SHALL cover: addu stream during DIV_WAIT -> stall=0 throughout, shadow_cnt counts 10->0.
REQ-036 Bench SHALL cover: MDU model holding busy one extra cycle after a mult -> proto_err=1 sticky, stall asserted for the extra cycle.
REQ-037 Bench SHALL cover: reset at shadow_cnt=7 in DIV_WAIT, then mfhi with mdu_busy=0 -> mfhi not stalled, counters 0 after reset.
